// File: rtl/variable_delay_line.sv
// Runtime-programmable delay line: circular buffer with one write pointer and
// an offset read pointer; ovalid marks outputs that are true D-cycle-old samples.
module variable_delay_line #(
  parameter int unsigned N         = 8,
  parameter int unsigned MAX_DELAY = 16,
  parameter int unsigned AW        = $clog2(MAX_DELAY + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] delay_sel,
  input  logic [N-1:0]  idata,
  output logic [N-1:0]  odata,
  output logic          ovalid,
  output logic          cfg_err
);

  localparam int unsigned PW = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;

  localparam logic [0:0] S_FILL = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [N-1:0]  mem_q [MAX_DELAY];
  logic [PW-1:0] wp_q, wp_d;
  logic [AW-1:0] cur_d_q, cur_d_d;
  logic [AW-1:0] fill_q, fill_d;
  logic [0:0]    state_q, state_d;
  logic          cfg_err_q, cfg_err_d;
  logic [AW-1:0] dsel_clamp_c;
  logic [AW-1:0] fill_inc_c;
  logic [AW:0]   rd_diff_c;
  logic [PW-1:0] rd_addr_c;

  // Clamp request, advance write pointer, and sequence fill/run.
  always_comb begin
    dsel_clamp_c = (delay_sel > AW'(MAX_DELAY)) ? AW'(MAX_DELAY) : delay_sel;
    cfg_err_d    = (delay_sel > AW'(MAX_DELAY));
    cur_d_d      = dsel_clamp_c;
    wp_d         = (wp_q == PW'(MAX_DELAY - 1)) ? '0 : wp_q + PW'(1);
    fill_inc_c   = fill_q + AW'(1);
    fill_d       = fill_q;
    state_d      = state_q;
    if (dsel_clamp_c != cur_d_q) begin
      fill_d  = '0;
      state_d = (dsel_clamp_c == '0) ? S_RUN : S_FILL;
    end else if (state_q == S_FILL) begin
      fill_d = fill_inc_c;
      if (fill_inc_c == cur_d_q) begin
        state_d = S_RUN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q      <= '0;
      fill_q    <= '0;
      cur_d_q   <= dsel_clamp_c;
      cfg_err_q <= 1'b0;
      state_q   <= (dsel_clamp_c == '0) ? S_RUN : S_FILL;
    end else begin
      wp_q      <= wp_d;
      fill_q    <= fill_d;
      cur_d_q   <= cur_d_d;
      cfg_err_q <= cfg_err_d;
      state_q   <= state_d;
    end
  end

  // Storage is never cleared; output gating hides stale contents.
  always_ff @(posedge clk) begin
    mem_q[wp_q] <= idata;
  end

  // Depth need not be a power of two, so wrap by adding MAX_DELAY on borrow.
  always_comb begin
    rd_diff_c = (AW+1)'(wp_q) - (AW+1)'(cur_d_q);
    if (rd_diff_c[AW]) begin
      rd_diff_c = rd_diff_c + (AW+1)'(MAX_DELAY);
    end
    rd_addr_c = PW'(rd_diff_c);
  end

  // D=0 bypasses storage; D=MAX_DELAY reads the slot about to be overwritten.
  always_comb begin
    ovalid = (state_q == S_RUN);
    odata  = '0;
    if (ovalid) begin
      odata = (cur_d_q == '0) ? idata : mem_q[rd_addr_c];
    end
    cfg_err = cfg_err_q;
  end

endmodule

// File: doc/variable_delay_line.md
# variable_delay_line

Runtime-programmable N-bit delay line built as a circular buffer with one write pointer and one offset read pointer. It complements the fixed register-chain delay line: the same latency function, but the delay is chosen per run from a control input rather than fixed at elaboration. It sits in data paths that need latency matching against a path whose latency is only known at run time. It reports when its output is a genuine delayed sample and when it is still filling.

## Interface

- N, 8, data width in bits
- MAX_DELAY, 16, largest supported delay in cycles; buffer depth; must be ≥1
- AW, $clog2(MAX_DELAY+1), width of delay_sel
- Clocking: one clock; reset is synchronous and active-high.
- clk  input  1  rising-edge clock; all state changes on posedge clk
- rst  input  1  synchronous, active-high reset
- delay_sel  input  AW  requested delay D in cycles, 0..MAX_DELAY; sampled every cycle
- idata  input  N  input sample; one sample accepted every cycle, no stall
- odata  output  N  idata delayed by D cycles; 0 while ovalid=0
- ovalid  output  1  high when odata carries a sample taken exactly D cycles earlier under the current D
- cfg_err  output  1  registered; high for each cycle following a cycle in which delay_sel > MAX_DELAY

## Operation

- Storage: mem[0..MAX_DELAY-1] of N bits, with asynchronous (distributed) read; wp is a mod-MAX_DELAY write pointer.
- Every cycle: mem[wp] <= idata; wp <= wp+1, wrapping MAX_DELAY-1 -> 0.
- Read address: (wp - cur_d) mod MAX_DELAY, computed with AW+1-bit arithmetic plus a conditional add of MAX_DELAY. Modulo-2^k wrap is not used because MAX_DELAY need not be a power of two.
- cur_d register: on each edge cur_d <= clamp(delay_sel) = min(delay_sel, MAX_DELAY). cfg_err <= (delay_sel > MAX_DELAY).
- fill counter, AW bits: saturates at cur_d.
- FSM, 2 states:
  - FILL: ovalid=0, odata=0. fill increments each cycle. Go to RUN when the next fill equals cur_d.
  - RUN: ovalid=1, odata=mem[read address].
- Delay change: if clamp(delay_sel) ≠ cur_d on an edge, then fill <= 0 and state <= FILL, or RUN if the new D=0. Buffer contents are kept, but output is suppressed until D fresh samples have been written.
- D=0: RUN immediately; odata=idata combinationally, ovalid=1. This is the only combinational data path.
- D=MAX_DELAY: the read address equals wp. The read occurs before the write in the same cycle, giving the oldest sample. Required behaviour; the RAM must read old data on a same-address read/write.
- Reset: wp=0, fill=0, cur_d<=clamp(delay_sel), cfg_err=0. State is RUN if clamp(delay_sel)=0, otherwise FILL. mem is not cleared; the odata gating hides its contents.

## Timing

- Reset values: odata=0, ovalid=0 (or odata=idata and ovalid=1 when the delay_sel present at reset is 0), cfg_err=0.
- Latency: with stable D≥1, odata in cycle t equals idata from cycle t-D, cycle-identical to a D-stage register chain.
- After reset release with constant D: ovalid rises in cycle D, counting the first post-reset cycle as cycle 0.
- After delay_sel changes to D' in cycle c: cur_d=D' from cycle c+1; ovalid low in cycles c+1..c+D'; ovalid high from c+1+D'.
- Reset mid-run overrides everything: it clears in-flight valid status in the next cycle, and stale samples never appear valid.
- cfg_err lags delay_sel by 1 cycle. An out-of-range request behaves exactly as delay_sel=MAX_DELAY.
- Throughput is 1 sample per cycle with no backpressure.

## Test plan

- MAX_DELAY=16, delay_sel=3, idata=ramp 1,2,3… after reset -> ovalid=0 in cycles 0–2; from cycle 3, odata = value input 3 cycles earlier (1,2,3…), and odata=0 while invalid.
- Run with D=3 past 40 cycles (wp wraps twice), then switch delay_sel to 7 -> ovalid low for exactly 7 cycles, then odata=idata(t-7) with no glitch sample.
- delay_sel=0 -> odata==idata in the same cycle, ovalid=1 continuously; then 0→16 -> 16 invalid cycles, then a 16-cycle delay across the wrap.
- delay_sel=20 with MAX_DELAY=16 -> cfg_err=1 the following cycle; data delayed by 16; returning to 16 causes no refill (cur_d unchanged).
- Assert rst for 1 cycle mid-run at D=5 -> ovalid=0 and odata=0 for 5 cycles after release; the first valid output is the first post-reset sample.
- Randomised delay_sel and idata for 10k cycles, checked against a reference model of a D-deep FIFO that flushes on change; also MAX_DELAY=5 (non-power-of-two) for pointer wrap.
